// File: rtl/mole_round_ctrl_if.sv
// mole_round_ctrl_if
//   Groups the game-side signals of the round sequencer into one bundle.
//   master : the environment side. It drives start, tick, the mole generator
//            position and the key strobe, and it observes the round outputs.
//   slave  : the round sequencer itself.
// Signals
//   start, tick, key_valid       : control strobes and levels into the sequencer
//   mole_pos, key_pos            : 3-bit positions
//   active_pos                   : position of the mole in the current round
//   mole_visible, mole_advance   : display enable and generator advance pulse
//   hit_pulse                    : one-cycle strobe for a scored hit
//   score, misses, game_over     : game status for the score/display logic
interface mole_round_ctrl_if #(
  parameter int SCORE_W = 8
);
  logic               start;
  logic               tick;
  logic [2:0]         mole_pos;
  logic               key_valid;
  logic [2:0]         key_pos;
  logic [2:0]         active_pos;
  logic               mole_visible;
  logic               mole_advance;
  logic               hit_pulse;
  logic [SCORE_W-1:0] score;
  logic [1:0]         misses;
  logic               game_over;

  modport master (
    output start, tick, mole_pos, key_valid, key_pos,
    input  active_pos, mole_visible, mole_advance, hit_pulse, score, misses, game_over
  );

  modport slave (
    input  start, tick, mole_pos, key_valid, key_pos,
    output active_pos, mole_visible, mole_advance, hit_pulse, score, misses, game_over
  );
endinterface

// File: rtl/mole_round_ctrl.sv
// mole_round_ctrl
//   Round sequencer for the whack-a-mole game. It latches the generator
//   position at each round load, keeps the mole visible for SHOW_TICKS ticks,
//   scores a hit on a matching key and counts a miss on timeout. A blank gap of
//   GAP_TICKS ticks separates rounds. The game ends after MAX_MISSES misses.
// Ports
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : game-side signal bundle (slave modport); every output is registered
module mole_round_ctrl #(
  parameter int SHOW_TICKS = 3,
  parameter int GAP_TICKS  = 1,
  parameter int MAX_MISSES = 3,
  parameter int SCORE_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  mole_round_ctrl_if.slave  bus
);

  localparam logic [3:0] SHOW_T = 4'(SHOW_TICKS);
  localparam logic [3:0] GAP_T  = 4'(GAP_TICKS);
  localparam logic [1:0] MAX_M  = 2'(MAX_MISSES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOW = 2'd1,
    ST_GAP  = 2'd2,
    ST_OVER = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         active_pos_q, active_pos_d;
  logic [3:0]         timer_q, timer_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [1:0]         misses_q, misses_d;
  logic               mole_visible_q, mole_visible_d;
  logic               mole_advance_q, mole_advance_d;
  logic               hit_pulse_q, hit_pulse_d;
  logic               game_over_q, game_over_d;

  logic [1:0]         misses_inc;

  assign misses_inc = misses_q + 2'd1;

  always_comb begin
    state_d        = state_q;
    active_pos_d   = active_pos_q;
    timer_d        = timer_q;
    score_d        = score_q;
    misses_d       = misses_q;
    mole_advance_d = 1'b0;
    hit_pulse_d    = 1'b0;

    case (state_q)
      ST_IDLE, ST_OVER: begin
        // Score and misses stay frozen in OVER so the display can show them.
        if (bus.start) begin
          score_d        = '0;
          misses_d       = 2'd0;
          active_pos_d   = bus.mole_pos;
          timer_d        = SHOW_T;
          state_d        = ST_SHOW;
          mole_advance_d = 1'b1;
        end
      end

      ST_SHOW: begin
        // A matching key wins over a simultaneous timeout tick; a wrong key
        // falls through so that a tick in the same cycle is still counted.
        if (bus.key_valid && (bus.key_pos == active_pos_q)) begin
          if (score_q != '1) begin
            score_d = score_q + 1'b1;
          end
          hit_pulse_d = 1'b1;
          timer_d     = GAP_T;
          state_d     = ST_GAP;
        end else if (bus.tick) begin
          if (timer_q == 4'd1) begin
            misses_d = misses_inc;
            if (misses_inc == MAX_M) begin
              state_d = ST_OVER;
            end else begin
              timer_d = GAP_T;
              state_d = ST_GAP;
            end
          end else begin
            timer_d = timer_q - 4'd1;
          end
        end
      end

      ST_GAP: begin
        if (bus.tick) begin
          if (timer_q == 4'd1) begin
            active_pos_d   = bus.mole_pos;
            timer_d        = SHOW_T;
            state_d        = ST_SHOW;
            mole_advance_d = 1'b1;
          end else begin
            timer_d = timer_q - 4'd1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Indicators are derived from the next state so that they are registered
    // and line up with the state they describe.
    mole_visible_d = (state_d == ST_SHOW);
    game_over_d    = (state_d == ST_OVER);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      active_pos_q   <= 3'd0;
      timer_q        <= 4'd0;
      score_q        <= '0;
      misses_q       <= 2'd0;
      mole_visible_q <= 1'b0;
      mole_advance_q <= 1'b0;
      hit_pulse_q    <= 1'b0;
      game_over_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      active_pos_q   <= active_pos_d;
      timer_q        <= timer_d;
      score_q        <= score_d;
      misses_q       <= misses_d;
      mole_visible_q <= mole_visible_d;
      mole_advance_q <= mole_advance_d;
      hit_pulse_q    <= hit_pulse_d;
      game_over_q    <= game_over_d;
    end
  end

  assign bus.active_pos   = active_pos_q;
  assign bus.mole_visible = mole_visible_q;
  assign bus.mole_advance = mole_advance_q;
  assign bus.hit_pulse    = hit_pulse_q;
  assign bus.score        = score_q;
  assign bus.misses       = misses_q;
  assign bus.game_over    = game_over_q;

endmodule

// File: doc/mole_round_ctrl.md
# mole_round_ctrl

Round sequencer for the whack-a-mole game: it decides when the mole moves, for how long it stays visible, and whether each round ends in a hit or a miss. It sits between the free-running 3-bit mole position generator, the keyboard decoder and the score/display logic. It samples the generator's position at the start of each round and pulses an advance enable back to it. It keeps score and miss count and ends the game after the configured number of misses.

## Interface
- SHOW_TICKS, 3: ticks a mole stays visible before the round counts as a miss (1..15).
- GAP_TICKS, 1: blank ticks between rounds (1..15).
- MAX_MISSES, 3: misses that end the game (1..3).
- SCORE_W, 8: score counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  level; start/restart request, sampled only in IDLE and OVER.
- tick  in  1  single-cycle game-time strobe from the prescaler.
- mole_pos  in  3  current position from the mole generator.
- key_valid  in  1  single-cycle strobe: a mole key was pressed.
- key_pos  in  3  position of the pressed key, valid with key_valid.
- active_pos  out  3  position of the mole in the current round.
- mole_visible  out  1  high while in SHOW.
- mole_advance  out  1  one-cycle enable to the mole generator.
- hit_pulse  out  1  one-cycle strobe on a scored hit.
- score  out  SCORE_W  hits this game, saturating.
- misses  out  2  misses this game.
- game_over  out  1  high while in OVER.

## Operation
- States: IDLE, SHOW, GAP, OVER.
- IDLE: all indicators low. If start=1, clear score and misses, then do a round load.
- Round load (one clock edge):
  - active_pos <= mole_pos.
  - timer <= SHOW_TICKS.
  - state <= SHOW.
  - mole_advance <= 1 for the next cycle only.
- SHOW (conditions in priority order):
  - key_valid=1 and key_pos==active_pos: score+1, saturating at 2^SCORE_W-1. hit_pulse <= 1 for one cycle. timer <= GAP_TICKS, state <= GAP.
  - key_valid=1 and key_pos!=active_pos: ignored. No penalty, no state change.
  - tick=1 and timer==1: timeout. misses+1. If the new misses equals MAX_MISSES, state <= OVER; otherwise timer <= GAP_TICKS, state <= GAP.
  - tick=1 and timer>1: timer-1.
- A matching hit in the same cycle as a timeout tick counts as a hit, and the tick is consumed.
- GAP: mole_visible=0 and keys are ignored. On tick, if timer==1 do a round load, else timer-1.
- OVER: game_over=1 and mole_visible=0. score and misses hold their values for display. start=1 clears score and misses and does a round load.
- start while in SHOW or GAP is ignored.
- Consecutive rounds may show the same position. No deduplication is done.
- timer width is 4 bits. Parameters outside their stated ranges are illegal.

## Timing
- All outputs are registered.
- Reset values:
  - state IDLE.
  - active_pos 0, timer 0, score 0, misses 0.
  - mole_visible, mole_advance, hit_pulse, game_over all 0.
- Reset is asynchronous. Asserting rst_n=0 mid-game clears everything immediately. The first edge after release evaluates IDLE.
- Latency:
  - start sampled at edge N: mole_visible=1, active_pos valid and mole_advance=1 during cycle N+1. mole_advance is low again from N+2.
  - Matching key at edge N: score updated, hit_pulse=1 and mole_visible=0 during cycle N+1.
- Visibility window: the mole is visible from round load until the SHOW_TICKS-th tick inside SHOW. That tick's edge ends the window.
- mole_advance never asserts outside a round load. hit_pulse never asserts outside SHOW exit.

## Test plan
- Reset/start: rst_n low, then start=1 with mole_pos=5 → next cycle active_pos=5, mole_visible=1, mole_advance=1 for exactly one cycle, score=0, misses=0.
- Hit: in SHOW with active_pos=5, key_valid with key_pos=5 → score=1, hit_pulse for one cycle, state GAP. After 1 tick (GAP_TICKS=1), a new round loads the current mole_pos.
- Wrong key then timeout: key_pos=2 while active_pos=5 → no change. 3 ticks → misses=1, state GAP.
- Game over: three consecutive timeouts → misses=3, game_over=1, mole_visible=0. start=1 → score=0, misses=0, SHOW.
- Simultaneous events: matching key_valid and the third tick in the same cycle → hit counted, misses unchanged. SCORE_W=2 with 4 hits → score saturates at 3.
- Async reset mid-SHOW: rst_n=0 between clock edges → all outputs 0 immediately. start is ignored while rst_n=0.
